// File: rtl/bisquare_s_shuf.sv
//------------------------------------------------------------------------------
// Module   : bisquare_s_shuf
// Brief    : Bipolar stochastic squarer (XNOR against an LFSR-shuffled history)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bisquare_s_shuf #(
  parameter int         DEP  = 3,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in,
  output logic out_valid,
  output logic out
);

  localparam int c_ENTRIES = 1 << DEP;
  // Bipolar-zero preload: entry i holds i[0], i.e. 0,1,0,1,... from index 0.
  localparam logic [c_ENTRIES-1:0] c_PRELOAD = {(c_ENTRIES/2){2'b10}};

  logic [7:0]           r_lfsr;
  logic [c_ENTRIES-1:0] r_buf;

  logic                 w_fb;
  logic [DEP-1:0]       w_idx;
  logic                 w_old;

  assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_idx = r_lfsr[DEP-1:0];
  assign w_old = r_buf[w_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr    <= SEED;
      r_buf     <= c_PRELOAD;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      // XNOR uses the entry before it is replaced by the incoming bit.
      out          <= ~(in ^ w_old);
      r_buf[w_idx] <= in;
      r_lfsr       <= {r_lfsr[6:0], w_fb};
      out_valid    <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bisquare_s_shuf.sv
//------------------------------------------------------------------------------
// Module   : tb_bisquare_s_shuf
// Brief    : Self-checking bench for bisquare_s_shuf (DEP=3 and DEP=5 copies)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bisquare_s_shuf;

  localparam logic [7:0] c_SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r_vld = 1'b0;
  logic r_in = 1'b0;
  logic w_ov3, w_o3, w_ov5, w_o5;

  int n_checks = 0;
  int n_fail = 0;

  // Reference: a bag of past bits addressed by a maximal-length 8-bit sequence.
  logic [7:0] m_lfsr;
  logic       m_b3[8];
  logic       m_b5[32];
  logic       m_o3, m_o5, m_v;

  always #5 clk = ~clk;

  bisquare_s_shuf #(.DEP(3), .SEED(c_SEED)) dut3 (
    .clk(clk), .rst(rst), .in_valid(r_vld), .in(r_in),
    .out_valid(w_ov3), .out(w_o3)
  );

  bisquare_s_shuf #(.DEP(5), .SEED(c_SEED)) dut5 (
    .clk(clk), .rst(rst), .in_valid(r_vld), .in(r_in),
    .out_valid(w_ov5), .out(w_o5)
  );

  task automatic m_reset();
    m_lfsr = c_SEED;
    for (int i = 0; i < 8; i++)  m_b3[i] = (i % 2 == 1);
    for (int i = 0; i < 32; i++) m_b5[i] = (i % 2 == 1);
    m_o3 = 1'b0;
    m_o5 = 1'b0;
    m_v  = 1'b0;
  endtask

  task automatic m_step(input logic v, input logic b);
    int i3, i5;
    if (v) begin
      i3 = m_lfsr % 8;
      i5 = m_lfsr % 32;
      m_o3 = (b == m_b3[i3]);
      m_o5 = (b == m_b5[i5]);
      m_b3[i3] = b;
      m_b5[i5] = b;
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      m_v = 1'b1;
    end else begin
      m_v = 1'b0;
    end
  endtask

  // One clock: drive on negedge, update model at posedge, leave #1 for sampling.
  task automatic drive(input logic v, input logic b, input logic r);
    @(negedge clk);
    rst   = r;
    r_vld = v;
    r_in  = b;
    @(posedge clk);
    if (r) m_reset();
    else   m_step(v, b);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b1);
      n_checks++;
      if ({w_ov3, w_o3, w_ov5, w_o5} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_out cyc%0d: got ov3/o3/ov5/o5=%b%b%b%b need 0000",
                 k, w_ov3, w_o3, w_ov5, w_o5);
      end
    end
  endtask

  task automatic test_first_bit();
    for (int b = 1; b >= 0; b--) begin
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b1, b[0], 1'b0);
      n_checks++;
      if ({w_ov3, w_o3, w_ov5, w_o5} !== {1'b1, b[0], 1'b1, b[0]}) begin
        n_fail++;
        $display("FAIL first_bit in=%0d: got ov3/o3/ov5/o5=%b%b%b%b need %b%b%b%b",
                 b, w_ov3, w_o3, w_ov5, w_o5, 1'b1, b[0], 1'b1, b[0]);
      end
    end
  endtask

  task automatic test_saturation();
    for (int b = 1; b >= 0; b--) begin
      int bad = 0;
      drive(1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 300; k++) begin
        drive(1'b1, b[0], 1'b0);
        if (k >= 256 && (w_o3 !== 1'b1 || w_o5 !== 1'b1 || w_ov3 !== 1'b1)) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL saturation in=%0d: got %0d non-one outputs need 0", b, bad);
      end
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    logic last3, last5;
    drive(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 60; k++) begin
      drive(1'b1, 1'($urandom), 1'b0);
      if (w_o3 !== m_o3 || w_o5 !== m_o5) bad++;
    end
    last3 = m_o3;
    last5 = m_o5;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'($urandom), 1'b0);
      n_checks++;
      if (w_ov3 !== 1'b0 || w_ov5 !== 1'b0 || w_o3 !== last3 || w_o5 !== last5) begin
        n_fail++;
        $display("FAIL stall_gap cyc%0d: got ov3/o3/ov5/o5=%b%b%b%b need 0%b0%b",
                 k, w_ov3, w_o3, w_ov5, w_o5, last3, last5);
      end
    end
    for (int k = 0; k < 60; k++) begin
      drive(1'b1, 1'($urandom), 1'b0);
      if (w_o3 !== m_o3 || w_o5 !== m_o5 || w_ov3 !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_model: got %0d mismatching cycles need 0", bad);
    end
  endtask

  task automatic test_stats(input int quarter_ones, input int lo, input int hi);
    int ones = 0;
    int bad  = 0;
    drive(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4096; k++) begin
      drive(1'b1, ($urandom_range(0, 3) < quarter_ones), 1'b0);
      if (w_o5) ones++;
      if (w_o5 !== m_o5 || w_o3 !== m_o3) bad++;
    end
    n_checks++;
    if (ones < lo || ones > hi) begin
      n_fail++;
      $display("FAIL stats_density q=%0d: got %0d ones need %0d..%0d",
               quarter_ones, ones, lo, hi);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stats_model q=%0d: got %0d mismatches need 0", quarter_ones, bad);
    end
  endtask

  task automatic test_mid_reset();
    logic rec_in[100], rec_o3[100], rec_o5[100];
    int bad = 0;
    drive(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 1000; k++) begin
      logic b = 1'($urandom);
      drive(1'b1, b, 1'b0);
      if (w_o3 !== m_o3 || w_o5 !== m_o5) bad++;
      if (k < 100) begin
        rec_in[k] = b;
        rec_o3[k] = w_o3;
        rec_o5[k] = w_o5;
      end
    end
    drive(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, rec_in[k], 1'b0);
      if (w_o3 !== rec_o3[k] || w_o5 !== rec_o5[k] || w_o3 !== m_o3) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mid_reset_replay: got %0d mismatches need 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    drive(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 500; k++) begin
      logic v = ($urandom_range(0, 3) != 0);
      drive(v, 1'($urandom), 1'b0);
      if (w_ov3 !== m_v || w_ov5 !== m_v || w_o3 !== m_o3 || w_o5 !== m_o5) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL random_gaps_model: got %0d mismatches need 0", bad);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_first_bit();
    test_saturation();
    test_stall();
    test_stats(3, 2438, 2682);
    test_stats(2, 1926, 2170);
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
